// File: rtl/ovc_credit_status.sv
// Output-VC credit and ownership tracking ahead of the VC/SW allocator.
// Registered availability / not-full vectors plus DfD error reporting.
module ovc_credit_status #(
    parameter int V = 4,
    parameter int P = 5,
    parameter int B = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [P*V-1:0]                    ovc_allocated_all,
    input  logic [P*V-1:0]                    flit_sent_all,
    input  logic [P*V-1:0]                    tail_sent_all,
    input  logic [P*V-1:0]                    credit_in_all,
    output logic [P*V-1:0]                    ovc_available_all,
    output logic [P*V-1:0]                    ovc_not_full_all,
    output logic [P*V*$clog2(B+1)-1:0]        credit_cnt_all,
    output logic                              err_sticky,
    output logic                              trigger,
    output logic [31:0]                       trace_signal
);

    localparam int N     = P * V;
    localparam int CRDTw = $clog2(B + 1);
    localparam logic [CRDTw-1:0] LB = CRDTw'(B);

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_ALLOC = 2'd1,
        S_DRAIN = 2'd2
    } ovc_state_t;

    ovc_state_t       r_state     [N];
    ovc_state_t       w_state_nxt [N];
    logic [CRDTw-1:0] r_cnt       [N];
    logic [CRDTw-1:0] w_cnt_nxt   [N];
    logic [3:0]       w_err       [N];

    logic [N-1:0]     w_inc;
    logic [N-1:0]     w_dec;
    logic             w_hit;
    logic [31:0]      w_trace;
    logic [7:0]       w_code;

    logic             r_err_sticky;
    logic             r_trigger;
    logic [31:0]      r_trace;

    // Simultaneous send and return cancel out.
    assign w_inc = credit_in_all & ~flit_sent_all;
    assign w_dec = flit_sent_all & ~credit_in_all;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i]   = r_cnt[i];
            w_state_nxt[i] = r_state[i];
            w_err[i]       = 4'b0000;

            if (w_inc[i]) begin
                if (r_cnt[i] == LB) w_err[i][0] = 1'b1;
                else                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
            if (w_dec[i]) begin
                if (r_cnt[i] == '0) w_err[i][1] = 1'b1;
                else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
            end

            case (r_state[i])
                S_FREE: begin
                    if (ovc_allocated_all[i])
                        w_state_nxt[i] = S_ALLOC;
                    else if (flit_sent_all[i])
                        w_err[i][3] = 1'b1;
                    if (tail_sent_all[i]) w_err[i][3] = 1'b1;
                end
                S_ALLOC: begin
                    if (ovc_allocated_all[i]) w_err[i][2] = 1'b1;
                    if (tail_sent_all[i]) w_state_nxt[i] = S_DRAIN;
                end
                S_DRAIN: begin
                    if (ovc_allocated_all[i]) w_err[i][2] = 1'b1;
                    if (tail_sent_all[i]) w_err[i][3] = 1'b1;
                    if (r_cnt[i] == LB) w_state_nxt[i] = S_FREE;
                end
                default: w_state_nxt[i] = S_FREE;
            endcase
        end
    end

    // Descending scan so the lowest erroring OVC is reported.
    always_comb begin
        w_hit   = 1'b0;
        w_trace = '0;
        w_code  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (|w_err[i]) begin
                w_hit = 1'b1;
                if (w_err[i][0])      w_code = 8'd1;
                else if (w_err[i][1]) w_code = 8'd2;
                else if (w_err[i][2]) w_code = 8'd3;
                else                  w_code = 8'd4;
                w_trace              = '0;
                w_trace[31:24]       = w_code;
                w_trace[23:16]       = 8'(i / V);
                w_trace[15:8]        = 8'(i % V);
                w_trace[CRDTw-1:0]   = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i]   <= LB;
                r_state[i] <= S_FREE;
            end
            r_err_sticky <= 1'b0;
            r_trigger    <= 1'b0;
            r_trace      <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i]   <= w_cnt_nxt[i];
                r_state[i] <= w_state_nxt[i];
            end
            r_trigger <= w_hit;
            if (w_hit) begin
                r_err_sticky <= 1'b1;
                r_trace      <= w_trace;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign ovc_available_all[g]            = (r_state[g] == S_FREE);
        assign ovc_not_full_all[g]             = (r_cnt[g] != '0);
        assign credit_cnt_all[g*CRDTw +: CRDTw] = r_cnt[g];
    end

    assign err_sticky   = r_err_sticky;
    assign trigger      = r_trigger;
    assign trace_signal = r_trace;

endmodule

// File: tb/tb_ovc_credit_status.sv
// Directed bench for ovc_credit_status (P=5, V=4, B=4).
// Each task drives a scenario and checks registered outputs after the edge.
module tb_ovc_credit_status;

    localparam int V  = 4;
    localparam int P  = 5;
    localparam int B  = 4;
    localparam int N  = P * V;
    localparam int CW = 3;

    logic            clk;
    logic            reset;
    logic [N-1:0]    alloc;
    logic [N-1:0]    flit;
    logic [N-1:0]    tail;
    logic [N-1:0]    cred;
    logic [N-1:0]    avail;
    logic [N-1:0]    nfull;
    logic [N*CW-1:0] cnt_all;
    logic            err_sticky;
    logic            trigger;
    logic [31:0]     trace;

    int n_pass  = 0;
    int n_total = 0;

    ovc_credit_status #(.V(V), .P(P), .B(B)) dut (
        .clk               (clk),
        .reset             (reset),
        .ovc_allocated_all (alloc),
        .flit_sent_all     (flit),
        .tail_sent_all     (tail),
        .credit_in_all     (cred),
        .ovc_available_all (avail),
        .ovc_not_full_all  (nfull),
        .credit_cnt_all    (cnt_all),
        .err_sticky        (err_sticky),
        .trigger           (trigger),
        .trace_signal      (trace)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cnt(input int i);
        return cnt_all[i*CW +: CW];
    endfunction

    // Advance one edge, then clear all strobes away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        alloc = '0;
        flit  = '0;
        tail  = '0;
        cred  = '0;
    endtask

    task automatic test_reset();
        logic [N*CW-1:0] exp_cnt;
        for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = 3'd4;
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        n_total++;
        if (cnt_all !== exp_cnt)
            $display("FAIL reset_cnt got=%h exp=%h", cnt_all, exp_cnt);
        else n_pass++;
        n_total++;
        if (avail !== 20'hFFFFF)
            $display("FAIL reset_avail got=%h exp=fffff", avail);
        else n_pass++;
        n_total++;
        if (nfull !== 20'hFFFFF)
            $display("FAIL reset_nfull got=%h exp=fffff", nfull);
        else n_pass++;
        n_total++;
        if ({err_sticky, trigger, trace} !== 34'd0)
            $display("FAIL reset_err got=%b%b %h exp=0", err_sticky, trigger, trace);
        else n_pass++;
    endtask

    task automatic test_alloc_send();
        logic [CW-1:0] exp_c;
        alloc[6] = 1'b1;
        cycle();
        n_total++;
        if (avail !== 20'hFFFBF)
            $display("FAIL alloc6_avail got=%h exp=fffbf", avail);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            flit[6] = 1'b1;
            if (k == 3) tail[6] = 1'b1;
            cycle();
            exp_c = 3'(3 - k);
            n_total++;
            if (cnt(6) !== exp_c)
                $display("FAIL send6_cnt k=%0d got=%0d exp=%0d", k, cnt(6), exp_c);
            else n_pass++;
        end
        n_total++;
        if (nfull[6] !== 1'b0 || nfull[5] !== 1'b1)
            $display("FAIL send6_nfull got=%h exp=fffbf", nfull);
        else n_pass++;
        n_total++;
        if (err_sticky !== 1'b0)
            $display("FAIL send6_noerr got=%b exp=0", err_sticky);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [CW-1:0] exp_c;
        for (int k = 0; k < 4; k++) begin
            cred[6] = 1'b1;
            cycle();
            exp_c = 3'(k + 1);
            n_total++;
            if (cnt(6) !== exp_c || avail[6] !== 1'b0)
                $display("FAIL drain6 k=%0d got cnt=%0d av=%b exp cnt=%0d av=0",
                         k, cnt(6), avail[6], exp_c);
            else n_pass++;
        end
        cycle();
        n_total++;
        if (avail[6] !== 1'b1 || cnt(6) !== 3'd4)
            $display("FAIL drain6_free got av=%b cnt=%0d exp av=1 cnt=4", avail[6], cnt(6));
        else n_pass++;
        n_total++;
        if (err_sticky !== 1'b0 || trigger !== 1'b0)
            $display("FAIL drain6_noerr got=%b%b exp=00", err_sticky, trigger);
        else n_pass++;
    endtask

    task automatic test_simul_credit();
        alloc[2] = 1'b1;
        cycle();
        flit[2] = 1'b1;
        cycle();
        flit[2] = 1'b1;
        cycle();
        n_total++;
        if (cnt(2) !== 3'd2)
            $display("FAIL simul2_pre got=%0d exp=2", cnt(2));
        else n_pass++;
        flit[2] = 1'b1;
        cred[2] = 1'b1;
        cycle();
        n_total++;
        if (cnt(2) !== 3'd2 || trigger !== 1'b0 || err_sticky !== 1'b0)
            $display("FAIL simul2 got cnt=%0d trg=%b err=%b exp cnt=2 trg=0 err=0",
                     cnt(2), trigger, err_sticky);
        else n_pass++;
    endtask

    task automatic test_double_alloc();
        alloc[9] = 1'b1;
        cycle();
        n_total++;
        if (trigger !== 1'b0 || avail[9] !== 1'b0)
            $display("FAIL alloc9_first got trg=%b av=%b exp trg=0 av=0", trigger, avail[9]);
        else n_pass++;
        cycle();
        cycle();
        alloc[9] = 1'b1;
        cycle();
        n_total++;
        if (trigger !== 1'b1 || trace !== 32'h03020104 || err_sticky !== 1'b1)
            $display("FAIL alloc9_err got trg=%b tr=%h err=%b exp trg=1 tr=03020104 err=1",
                     trigger, trace, err_sticky);
        else n_pass++;
        cycle();
        n_total++;
        if (trigger !== 1'b0 || trace !== 32'h03020104 || avail[9] !== 1'b0)
            $display("FAIL alloc9_hold got trg=%b tr=%h av=%b exp trg=0 tr=03020104 av=0",
                     trigger, trace, avail[9]);
        else n_pass++;
    endtask

    task automatic test_overflow_reset();
        logic [N*CW-1:0] exp_cnt;
        cred[0]  = 1'b1;
        cred[19] = 1'b1;
        cycle();
        n_total++;
        if (trigger !== 1'b1 || trace !== 32'h01000004)
            $display("FAIL ovf got trg=%b tr=%h exp trg=1 tr=01000004", trigger, trace);
        else n_pass++;
        n_total++;
        if (cnt(0) !== 3'd4 || cnt(19) !== 3'd4)
            $display("FAIL ovf_cnt got c0=%0d c19=%0d exp 4 4", cnt(0), cnt(19));
        else n_pass++;
        cycle();
        n_total++;
        if (trigger !== 1'b0)
            $display("FAIL ovf_pulse got=%b exp=0", trigger);
        else n_pass++;
        for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = 3'd4;
        reset    = 1'b0;
        flit[6]  = 1'b1;
        alloc[6] = 1'b1;
        cred[2]  = 1'b1;
        cycle();
        reset = 1'b1;
        n_total++;
        if (cnt_all !== exp_cnt || avail !== 20'hFFFFF || nfull !== 20'hFFFFF)
            $display("FAIL midreset got cnt=%h av=%h nf=%h exp cnt=%h av=fffff nf=fffff",
                     cnt_all, avail, nfull, exp_cnt);
        else n_pass++;
        n_total++;
        if ({err_sticky, trigger, trace} !== 34'd0)
            $display("FAIL midreset_err got=%b%b %h exp=0", err_sticky, trigger, trace);
        else n_pass++;
    endtask

    task automatic test_underflow();
        alloc[5] = 1'b1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            flit[5] = 1'b1;
            cycle();
        end
        n_total++;
        if (cnt(5) !== 3'd0 || err_sticky !== 1'b0)
            $display("FAIL udf_pre got cnt=%0d err=%b exp 0 0", cnt(5), err_sticky);
        else n_pass++;
        flit[5] = 1'b1;
        cycle();
        n_total++;
        if (trigger !== 1'b1 || trace !== 32'h02010100 || cnt(5) !== 3'd0)
            $display("FAIL udf got trg=%b tr=%h cnt=%0d exp trg=1 tr=02010100 cnt=0",
                     trigger, trace, cnt(5));
        else n_pass++;
    endtask

    task automatic test_tail_free();
        cycle();
        flit[13] = 1'b1;
        tail[13] = 1'b1;
        cycle();
        n_total++;
        if (trigger !== 1'b1 || trace !== 32'h04030104)
            $display("FAIL tailfree got trg=%b tr=%h exp trg=1 tr=04030104", trigger, trace);
        else n_pass++;
        n_total++;
        if (cnt(13) !== 3'd3 || avail[13] !== 1'b1)
            $display("FAIL tailfree_st got cnt=%0d av=%b exp cnt=3 av=1", cnt(13), avail[13]);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        alloc = '0;
        flit  = '0;
        tail  = '0;
        cred  = '0;
        test_reset();
        test_alloc_send();
        test_drain();
        test_simul_credit();
        test_double_alloc();
        test_overflow_reset();
        test_underflow();
        test_tail_free();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
